// File: rtl/clock_pkg.sv
// Shared mode encodings, BCD limits and BCD arithmetic helpers for the
// doomsday clock timekeeping core.
package clock_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_SET  = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam int DIGIT_W = 4;
  localparam int PAIR_W  = 2 * DIGIT_W;
  localparam int TIME_W  = 4 * DIGIT_W;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  // Two-digit BCD increment that wraps from maxVal back to zero.
  function automatic logic [PAIR_W-1:0] bcdInc(input logic [PAIR_W-1:0] v, input int maxVal);
    logic [DIGIT_W-1:0] maxTens;
    logic [DIGIT_W-1:0] maxUnits;
    maxTens  = DIGIT_W'(maxVal / 10);
    maxUnits = DIGIT_W'(maxVal % 10);
    if (v == {maxTens, maxUnits})
      return '0;
    else if (v[DIGIT_W-1:0] == DIGIT_W'(9))
      return {v[PAIR_W-1:DIGIT_W] + DIGIT_W'(1), DIGIT_W'(0)};
    else
      return {v[PAIR_W-1:DIGIT_W], v[DIGIT_W-1:0] + DIGIT_W'(1)};
  endfunction

  // Two-digit BCD decrement that wraps from zero up to maxVal.
  function automatic logic [PAIR_W-1:0] bcdDec(input logic [PAIR_W-1:0] v, input int maxVal);
    logic [DIGIT_W-1:0] maxTens;
    logic [DIGIT_W-1:0] maxUnits;
    maxTens  = DIGIT_W'(maxVal / 10);
    maxUnits = DIGIT_W'(maxVal % 10);
    if (v == '0)
      return {maxTens, maxUnits};
    else if (v[DIGIT_W-1:0] == '0)
      return {v[PAIR_W-1:DIGIT_W] - DIGIT_W'(1), DIGIT_W'(9)};
    else
      return {v[PAIR_W-1:DIGIT_W], v[DIGIT_W-1:0] - DIGIT_W'(1)};
  endfunction

  function automatic logic [TIME_W-1:0] timeInc(input logic [TIME_W-1:0] t);
    logic [PAIR_W-1:0] newSec;
    logic [PAIR_W-1:0] newMin;
    newSec = bcdInc(t[PAIR_W-1:0], SEC_MAX);
    newMin = (newSec == '0) ? bcdInc(t[TIME_W-1:PAIR_W], MIN_MAX) : t[TIME_W-1:PAIR_W];
    return {newMin, newSec};
  endfunction

  function automatic logic [TIME_W-1:0] timeDec(input logic [TIME_W-1:0] t);
    logic [PAIR_W-1:0] newMin;
    newMin = (t[PAIR_W-1:0] == '0) ? bcdDec(t[TIME_W-1:PAIR_W], MIN_MAX) : t[TIME_W-1:PAIR_W];
    return {newMin, bcdDec(t[PAIR_W-1:0], SEC_MAX)};
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for one raw push-button followed by a registered
// rising-edge pulse, so a held button yields exactly one event.
module btn_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/clock_functions.sv
// Doomsday clock timekeeping core: BCD mm:ss with run-up, set, countdown
// and hold modes, a self-generated 1 Hz tick and a half-second blink.
module clock_functions
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [1:0]        buttonsInput,
  output logic [TIME_W-1:0] big_bin,
  output logic              alarm,
  output logic              blink
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

  logic [CNT_W-1:0]  r_count;
  logic              r_blink;
  logic [TIME_W-1:0] r_time;
  logic              r_alarm;
  logic              w_tick;
  logic [CNT_W-1:0]  w_countNext;
  logic [TIME_W-1:0] w_timeDec;
  logic [1:0]        w_btnEvent;

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_edge_sync u_sync (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_btn  (buttonsInput[gi]),
      .o_pulse(w_btnEvent[gi])
    );
  end

  assign w_tick      = (r_count == CNT_LAST);
  assign w_countNext = w_tick ? '0 : r_count + CNT_W'(1);
  assign w_timeDec   = timeDec(r_time);

  // blink is registered from the next count so it always matches r_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_blink <= 1'b1;
    end else begin
      r_count <= w_countNext;
      r_blink <= (w_countNext < CNT_HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_time  <= '0;
      r_alarm <= 1'b0;
    end else begin
      case (mode)
        MODE_RUN: begin
          r_alarm <= 1'b0;
          if (w_tick)
            r_time <= timeInc(r_time);
        end
        MODE_SET: begin
          r_alarm <= 1'b0;
          r_time  <= {w_btnEvent[1] ? bcdInc(r_time[TIME_W-1:PAIR_W], MIN_MAX) : r_time[TIME_W-1:PAIR_W],
                      w_btnEvent[0] ? bcdInc(r_time[PAIR_W-1:0], SEC_MAX)      : r_time[PAIR_W-1:0]};
        end
        MODE_DOWN: begin
          if (w_tick) begin
            if (r_time != '0) begin
              r_time <= w_timeDec;
              if (w_timeDec == '0)
                r_alarm <= 1'b1;
            end else begin
              r_alarm <= 1'b1;
            end
          end
        end
        default: begin
          if (|w_btnEvent)
            r_alarm <= 1'b0;
        end
      endcase
    end
  end

  assign big_bin = r_time;
  assign alarm   = r_alarm;
  assign blink   = r_blink;

endmodule

// File: tb/tb_clock_functions.sv
// Self-checking bench for clock_functions: directed scenarios plus random
// traffic, compared every cycle against a seconds-based reference model.
module tb_clock_functions;
  import clock_pkg::*;

  localparam int TICK_DIV = 10;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [1:0]  buttonsInput;
  logic [15:0] big_bin;
  logic        alarm;
  logic        blink;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  // Reference model: time as plain seconds, prescaler as a phase counter,
  // button path as a history of raw samples (event = rise seen 3 edges ago).
  int         mTime  = 0;
  logic       mAlarm = 1'b0;
  int         mPhase = 0;
  logic [1:0] hist [1:4];

  clock_functions #(.TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .buttonsInput(buttonsInput),
    .big_bin     (big_bin),
    .alarm       (alarm),
    .blink       (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int t);
    int m;
    int s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void modelEdge();
    logic       tick;
    logic [1:0] ev;
    int         mm;
    int         ss;
    if (rst) begin
      mTime  = 0;
      mAlarm = 1'b0;
      mPhase = 0;
      for (int i = 1; i <= 4; i++) hist[i] = 2'b00;
    end else begin
      tick    = (mPhase == TICK_DIV - 1);
      ev      = hist[3] & ~hist[4];
      hist[4] = hist[3];
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = buttonsInput;
      mPhase  = (mPhase + 1) % TICK_DIV;
      case (mode)
        MODE_RUN: begin
          mAlarm = 1'b0;
          if (tick) mTime = (mTime + 1) % 3600;
        end
        MODE_SET: begin
          mAlarm = 1'b0;
          mm = mTime / 60;
          ss = mTime % 60;
          if (ev[1]) mm = (mm + 1) % 60;
          if (ev[0]) ss = (ss + 1) % 60;
          mTime = mm * 60 + ss;
        end
        MODE_DOWN: begin
          if (tick) begin
            if (mTime != 0) begin
              mTime = mTime - 1;
              if (mTime == 0) mAlarm = 1'b1;
            end else begin
              mAlarm = 1'b1;
            end
          end
        end
        default: begin
          if (ev != 2'b00) mAlarm = 1'b0;
        end
      endcase
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic [1:0] modeV, input logic [1:0] btnV);
    rst          = rstV;
    mode         = modeV;
    buttonsInput = btnV;
  endtask

  // One clock edge: advance the model, then compare all outputs 1 ns later.
  task automatic stepClock();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("model big_bin", big_bin, toBcd(mTime));
    checkOutput("model alarm", {15'd0, alarm}, {15'd0, mAlarm});
    checkOutput("model blink", {15'd0, blink}, {15'd0, (mPhase < TICK_DIV / 2)});
  endtask

  task automatic pressButton(input logic [1:0] modeV, input logic [1:0] mask, input int hiLen, input int loLen);
    applyStimulus(1'b0, modeV, mask);
    repeat (hiLen) stepClock();
    applyStimulus(1'b0, modeV, 2'b00);
    repeat (loLen) stepClock();
  endtask

  task automatic doReset(input int cycles);
    applyStimulus(1'b1, MODE_RUN, 2'b00);
    repeat (cycles) stepClock();
    applyStimulus(1'b0, MODE_RUN, 2'b00);
  endtask

  initial begin
    int         guard;
    logic [1:0] curMode;
    logic       rstV;
    logic [1:0] btnV;

    for (int i = 1; i <= 4; i++) hist[i] = 2'b00;
    applyStimulus(1'b1, MODE_RUN, 2'b00);

    $display("[TB] reset then run-up for 600 ticks");
    doReset(3);
    checkOutput("reset big_bin", big_bin, 16'h0000);
    checkOutput("reset blink", {15'd0, blink}, 16'h0001);
    for (int c = 1; c <= 6000; c++) begin
      stepClock();
      if (c == 10)  checkOutput("first tick", big_bin, 16'h0001);
      if (c == 590) checkOutput("run 00:59", big_bin, 16'h0059);
      if (c == 600) checkOutput("run 01:00", big_bin, 16'h0100);
    end
    checkOutput("run 10:00", big_bin, 16'h1000);

    $display("[TB] set wrap and run-up wrap");
    doReset(2);
    for (int i = 0; i < 59; i++) pressButton(MODE_SET, 2'b10, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
    for (int i = 0; i < 59; i++) pressButton(MODE_SET, 2'b01, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
    repeat (4) stepClock();
    checkOutput("set 59:59", big_bin, 16'h5959);
    pressButton(MODE_SET, 2'b11, 2, 4);
    checkOutput("both at 59:59", big_bin, 16'h0000);
    for (int i = 0; i < 59; i++) pressButton(MODE_SET, 2'b11, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    repeat (4) stepClock();
    checkOutput("both x59", big_bin, 16'h5959);
    applyStimulus(1'b0, MODE_RUN, 2'b00);
    repeat (TICK_DIV) stepClock();
    checkOutput("run wrap", big_bin, 16'h0000);

    $display("[TB] held button and event latency");
    pressButton(MODE_SET, 2'b01, 100, 5);
    checkOutput("held bit0", big_bin, 16'h0001);
    applyStimulus(1'b0, MODE_SET, 2'b10);
    stepClock();
    checkOutput("latency n", big_bin, 16'h0001);
    applyStimulus(1'b0, MODE_SET, 2'b00);
    stepClock();
    checkOutput("latency n+1", big_bin, 16'h0001);
    stepClock();
    checkOutput("latency n+2", big_bin, 16'h0001);
    stepClock();
    checkOutput("latency n+3", big_bin, 16'h0101);

    $display("[TB] countdown to alarm");
    doReset(1);
    for (int i = 0; i < 3; i++) pressButton(MODE_SET, 2'b01, 1, 2);
    repeat (4) stepClock();
    checkOutput("set 00:03", big_bin, 16'h0003);
    applyStimulus(1'b0, MODE_DOWN, 2'b00);
    guard = 0;
    while (alarm !== 1'b1 && guard < 40) begin
      stepClock();
      guard++;
    end
    checkOutput("alarm rise", {15'd0, alarm}, 16'h0001);
    checkOutput("alarm at 0000", big_bin, 16'h0000);
    repeat (TICK_DIV + 2) stepClock();
    checkOutput("expired hold", big_bin, 16'h0000);
    checkOutput("expired alarm", {15'd0, alarm}, 16'h0001);

    $display("[TB] alarm clearing");
    applyStimulus(1'b0, MODE_HOLD, 2'b00);
    repeat (3) stepClock();
    checkOutput("hold keeps alarm", {15'd0, alarm}, 16'h0001);
    pressButton(MODE_HOLD, 2'b01, 1, 3);
    checkOutput("hold clear alarm", {15'd0, alarm}, 16'h0000);
    checkOutput("hold time", big_bin, 16'h0000);
    applyStimulus(1'b0, MODE_DOWN, 2'b00);
    guard = 0;
    while (alarm !== 1'b1 && guard < 15) begin
      stepClock();
      guard++;
    end
    checkOutput("alarm again", {15'd0, alarm}, 16'h0001);
    applyStimulus(1'b0, MODE_RUN, 2'b00);
    stepClock();
    checkOutput("run clears alarm", {15'd0, alarm}, 16'h0000);

    $display("[TB] countdown borrow");
    doReset(1);
    pressButton(MODE_SET, 2'b10, 2, 4);
    checkOutput("set 01:00", big_bin, 16'h0100);
    applyStimulus(1'b0, MODE_DOWN, 2'b00);
    guard = 0;
    while (big_bin === 16'h0100 && guard < 12) begin
      stepClock();
      guard++;
    end
    checkOutput("borrow 00:59", big_bin, 16'h0059);

    $display("[TB] reset mid-count");
    doReset(1);
    for (int i = 0; i < 2; i++) pressButton(MODE_SET, 2'b10, 1, 2);
    for (int i = 0; i < 30; i++) pressButton(MODE_SET, 2'b01, 1, 1);
    repeat (4) stepClock();
    checkOutput("set 02:30", big_bin, 16'h0230);
    applyStimulus(1'b0, MODE_DOWN, 2'b00);
    repeat (int'($urandom_range(13, 27))) stepClock();
    applyStimulus(1'b1, MODE_DOWN, 2'b00);
    stepClock();
    checkOutput("mid rst time", big_bin, 16'h0000);
    checkOutput("mid rst alarm", {15'd0, alarm}, 16'h0000);
    checkOutput("mid rst blink", {15'd0, blink}, 16'h0001);
    applyStimulus(1'b0, MODE_RUN, 2'b00);
    repeat (TICK_DIV - 1) stepClock();
    checkOutput("no early tick", big_bin, 16'h0000);
    stepClock();
    checkOutput("tick restart", big_bin, 16'h0001);

    $display("[TB] random traffic");
    curMode = MODE_RUN;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) curMode = 2'($urandom_range(0, 3));
      rstV = ($urandom_range(0, 199) == 0);
      btnV = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      applyStimulus(rstV, curMode, btnV);
      stepClock();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/clock_functions.md
Name: clock_functions

Overview:
- Timekeeping core of the doomsday clock: a minutes:seconds value held as four BCD digits.
- Four modes: count up, manual set, count down to an alarm, freeze.
- Runs on the single system clock and generates its own 1 Hz tick enable.
- Its 16-bit BCD output feeds the seven-segment driver and the VGA digit renderer; its alarm and blink outputs drive the colour and colon-flash logic.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per 1 s tick. Must be ≥ 2; a bench uses a small value such as 10.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous, active-high reset.
- mode  input  2  operating mode: 00 run-up, 01 set, 10 countdown, 11 hold.
- buttonsInput  input  2  raw asynchronous push-buttons. Bit 1 adds one minute, bit 0 adds one second.
- big_bin  output  16  BCD time, fields listed below.
- alarm  output  1  high once the countdown has expired.
- blink  output  1  high for the first half of every second; drives the colon dots.

big_bin fields:
- [15:12] minute tens, 0-5.
- [11:8] minute units, 0-9.
- [7:4] second tens, 0-5.
- [3:0] second units, 0-9.

Behaviour:
- Reset: on a clk edge with rst=1, the following all clear:
  - big_bin = 16'h0000, alarm = 0;
  - prescaler = 0, blink = 1;
  - synchroniser and edge-detect flops = 0.
  - rst has priority over every other event.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1; it wraps to 0.
  - tick is an internal one-cycle pulse while the count equals TICK_DIV-1.
  - blink = (count < TICK_DIV/2).
  - The prescaler is never reset by mode changes.
- Buttons:
  - Each bit passes through a 2-flop synchroniser, then a rising-edge detector.
  - One press produces exactly one event, however long it is held.
  - A rise sampled at edge n updates big_bin at edge n+3.
- Digits are always held as legal BCD, so the time range is 00:00 to 59:59. All increments and decrements carry or borrow in BCD.
- Mode 00, run-up:
  - On tick, time advances by 1 s: 00:59 -> 01:00, 59:59 -> 00:00.
  - Button events are ignored.
  - alarm is forced to 0.
- Mode 01, set:
  - Ticks are ignored and alarm is forced to 0.
  - A bit-1 event increments minutes modulo 60, leaving seconds unchanged.
  - A bit-0 event increments seconds modulo 60 with no carry into minutes.
  - Simultaneous events on both bits apply both in the same cycle.
- Mode 10, countdown:
  - On tick with time ≠ 00:00, time decrements by 1 s (05:00 -> 04:59).
  - alarm is set on the same edge the value becomes 00:00.
  - On tick with time = 00:00, time holds and alarm = 1.
  - Button events are ignored.
- Mode 11, hold:
  - Time is frozen and alarm keeps its value.
  - Any button event clears alarm.
- Mode changes:
  - A change takes effect on the next edge, with no extra latency.
  - A tick coinciding with the change follows the new mode.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package clock_pkg holds:
  - mode constants MODE_RUN = 2'b00, MODE_SET = 2'b01, MODE_DOWN = 2'b10, MODE_HOLD = 2'b11;
  - BCD digit width 4;
  - limits SEC_MAX = 59, MIN_MAX = 59.
- One natural sub-module: btn_edge_sync, the 2-flop synchroniser plus rising-edge pulse, instantiated per button bit.
- BCD increment/decrement is implemented as functions in clock_pkg.

Test Plan:
- Reset then run (TICK_DIV=10): rst for 3 cycles, then mode=00 for 600 ticks. Expect big_bin 0000 -> 0001 each 10 cycles, 0059 -> 0100, and 10:00 (16'h1000) after 600 ticks. blink is high for cycles 0-4 of each period.
- Wrap in set then run: mode=01, 59 bit-1 presses and 59 bit-0 presses -> big_bin = 16'h5959. Switch to mode=00 and give one tick -> 16'h0000.
- Set boundaries:
  - Hold bit 0 high for 100 cycles -> exactly +1 s.
  - Both bits pressed together at 16'h5959 -> 16'h0000 with no carry.
  - Effect lands 3 cycles after the rising edge.
- Countdown:
  - Set 00:03, mode=10 -> 0002, 0001, then 0000 with alarm rising on the same edge.
  - A further tick keeps 0000 and alarm stays 1.
  - 01:00 -> 00:59 borrow checked separately.
- Alarm clearing:
  - With alarm=1, mode=11 plus a bit-0 press -> alarm 0, time unchanged.
  - Repeat with alarm=1 and mode=00 -> alarm 0 on the next edge.
- Reset mid-count: rst asserted mid-second in mode 10 at 16'h0230 -> next edge gives 0000, alarm 0, and tick timing restarts TICK_DIV cycles after rst drops.
